// File: rtl/dice_encoder.sv
// dice_encoder: converts a 7-LED dice display pattern into its face value.
// A pattern must be held for STABLE_CYC consecutive valid samples before it is
// offered on a valid/ready output; the same pattern is never offered twice in a
// row without an intervening change. Illegal patterns produce NUM=7, ERR=1 and
// are tallied in a saturating error counter when transferred.
module dice_encoder #(
    parameter int STABLE_CYC = 4
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [6:0] LED,
    input  logic       LED_VLD,
    output logic [2:0] NUM,
    output logic       NUM_VLD,
    input  logic       NUM_RDY,
    output logic       ERR,
    output logic [7:0] ERR_CNT
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SETTLE   = 2'd1,
        OUT      = 2'd2,
        WAIT_CHG = 2'd3
    } state_t;

    localparam logic [3:0] STABLE_C = 4'(STABLE_CYC);

    state_t     state;
    state_t     state_nxt;
    logic [6:0] pat;
    logic [6:0] pat_nxt;
    logic [3:0] cnt;
    logic [3:0] cnt_nxt;
    logic [3:0] cnt_inc;
    logic [2:0] num_nxt;
    logic       err_nxt;
    logic [7:0] err_cnt_nxt;

    // Map a display pattern to {err, num}; anything off the table is an error.
    function automatic logic [3:0] encode(input logic [6:0] p);
        logic [3:0] r;
        case (p)
            7'b0000000: r = {1'b0, 3'd0};
            7'b0001000: r = {1'b0, 3'd1};
            7'b0100010: r = {1'b0, 3'd2};
            7'b0101010: r = {1'b0, 3'd3};
            7'b1100011: r = {1'b0, 3'd4};
            7'b1101011: r = {1'b0, 3'd5};
            7'b1110111: r = {1'b0, 3'd6};
            default:    r = {1'b1, 3'd7};
        endcase
        return r;
    endfunction

    // Increment that sticks at the top of the range instead of wrapping.
    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign cnt_inc = cnt + 4'd1;

    // Next-state, pattern/counter updates and result capture on entry to OUT.
    always_comb begin
        state_nxt   = state;
        pat_nxt     = pat;
        cnt_nxt     = cnt;
        num_nxt     = NUM;
        err_nxt     = ERR;
        err_cnt_nxt = ERR_CNT;
        case (state)
            IDLE: begin
                if (LED_VLD) begin
                    pat_nxt   = LED;
                    cnt_nxt   = 4'd1;
                    state_nxt = (STABLE_C == 4'd1) ? OUT : SETTLE;
                end
            end
            SETTLE: begin
                if (!LED_VLD) begin
                    cnt_nxt   = 4'd0;
                    state_nxt = IDLE;
                end else if (LED == pat) begin
                    cnt_nxt = cnt_inc;
                    if (cnt_inc >= STABLE_C) begin
                        state_nxt = OUT;
                    end
                end else begin
                    // A different pattern restarts the stability window.
                    pat_nxt   = LED;
                    cnt_nxt   = 4'd1;
                    state_nxt = (STABLE_C == 4'd1) ? OUT : SETTLE;
                end
            end
            OUT: begin
                // Inputs are ignored while the result is being offered.
                if (NUM_RDY) begin
                    state_nxt = WAIT_CHG;
                    if (ERR) begin
                        err_cnt_nxt = sat_inc(ERR_CNT);
                    end
                end
            end
            WAIT_CHG: begin
                if (!LED_VLD) begin
                    cnt_nxt   = 4'd0;
                    state_nxt = IDLE;
                end else if (LED != pat) begin
                    pat_nxt   = LED;
                    cnt_nxt   = 4'd1;
                    state_nxt = (STABLE_C == 4'd1) ? OUT : SETTLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        // The result is frozen at OUT entry from the pattern being committed.
        if ((state != OUT) && (state_nxt == OUT)) begin
            {err_nxt, num_nxt} = encode(pat_nxt);
        end
    end

    // State, pattern, counters and registered outputs; reset clears everything.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state   <= IDLE;
            pat     <= 7'd0;
            cnt     <= 4'd0;
            NUM     <= 3'd0;
            ERR     <= 1'b0;
            NUM_VLD <= 1'b0;
            ERR_CNT <= 8'd0;
        end else begin
            state   <= state_nxt;
            pat     <= pat_nxt;
            cnt     <= cnt_nxt;
            NUM     <= num_nxt;
            ERR     <= err_nxt;
            NUM_VLD <= (state_nxt == OUT);
            ERR_CNT <= err_cnt_nxt;
        end
    end

endmodule
